ps2_keyboard_rx: RTL

- Receives PS/2 keyboard frames and turns them into 8-bit scan-code bytes.
- Keeps a "currently held key" register that the Hack keyboard memory-map word reads.
- Sits directly upstream of the 8-input OR reduction. That reduction consumes `key[7:0]` to produce the "any key down" flag.
- Fully synchronous to the system clock. `ps2_clk` is treated as a data signal, never as a clock.

---
 rtl/ps2_keyboard_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the pad signals, deframes 11-bit frames and tracks the held key.
// Define PS2_RX_PARITY_CHECK_EN to reject frames whose data plus parity bits do not hold odd parity.
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic [7:0] key
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic          clk_s1, clk_s2, clk_hist;
  logic          data_s1, data_s2;
  logic          fall;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          parity_good, parity_good_next;
  logic [CW-1:0] count, count_next;
  logic [7:0]    data_next, key_next;
  logic          valid_next, err_next;
  logic          break_pending, break_next;

  // Synchroniser flops idle high so leaving reset cannot look like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_hist & ~clk_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      parity_good   <= 1'b0;
      count         <= '0;
      data          <= '0;
      key           <= '0;
      valid         <= 1'b0;
      frame_err     <= 1'b0;
      break_pending <= 1'b0;
    end else begin
      state         <= state_next;
      bit_cnt       <= bit_cnt_next;
      shift         <= shift_next;
      parity_good   <= parity_good_next;
      count         <= count_next;
      data          <= data_next;
      key           <= key_next;
      valid         <= valid_next;
      frame_err     <= err_next;
      break_pending <= break_next;
    end
  end

  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    shift_next       = shift;
    parity_good_next = parity_good;
    count_next       = count;
    data_next        = data;
    key_next         = key;
    break_next       = break_pending;
    valid_next       = 1'b0;
    err_next         = 1'b0;

    // A stalled frame is dropped once the bus has been quiet for TIMEOUT_CYCLES clocks.
    if (state == IDLE || fall) begin
      count_next = '0;
    end else if (count == TIMEOUT_LAST) begin
      count_next = '0;
      state_next = IDLE;
      shift_next = '0;
      err_next   = 1'b1;
    end else begin
      count_next = count + CW'(1);
    end

    if (fall) begin
      case (state)
        IDLE: begin
          if (!data_s2) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {data_s2, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
          parity_good_next = ^{shift, data_s2};
`else
          parity_good_next = 1'b1;
`endif
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_s2 && parity_good) begin
            valid_next = 1'b1;
            data_next  = shift;
            // 0xE0 is only a prefix; 0xF0 arms the release of the next code.
            if (shift == 8'hF0) begin
              break_next = 1'b1;
            end else if (shift != 8'hE0) begin
              if (break_pending) begin
                key_next   = 8'h00;
                break_next = 1'b0;
              end else begin
                key_next = shift;
              end
            end
          end else begin
            err_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
